fetch_prefetch_unit: RTL

//  Instruction fetch stage upstream of the decoder. Owns the fetch PC and issues word reads to

---
 rtl/fetch_prefetch_unit_pkg.sv | 27 ++
 rtl/fetch_prefetch_unit_fifo.sv | 87 ++++++++
 rtl/fetch_prefetch_unit.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared fetch-stage definitions: FSM encodings, word geometry and queue entry layout.
package fetch_prefetch_unit_pkg;

    localparam int WORD_BYTES = 4;
    localparam int INSTR_W    = 32;
    localparam int ADDR_W     = 32;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_REQ   = 2'd1,
        FETCH_DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] word;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

    function automatic logic [ADDR_W-1:0] next_word(input logic [ADDR_W-1:0] addr);
        return addr + ADDR_W'(WORD_BYTES);
    endfunction

endpackage

// File: rtl/fetch_prefetch_unit_fifo.sv
// Prefetch queue: DEPTH x {pc, word} synchronous FIFO with first-word fall-through head and flush.
module prefetch_fifo
    import fetch_prefetch_unit_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_wdata,
    output fetch_entry_t o_head,
    output logic [CW-1:0] o_count
);

    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    fetch_entry_t  r_mem [DEPTH];
    logic          w_pop;

    assign w_pop = i_pop && (r_count != {CW{1'b0}});

    // Pointer and occupancy update; flush beats push and pop
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rd_ptr <= {PW{1'b0}};
            r_wr_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else if (i_flush) begin
            r_rd_ptr <= {PW{1'b0}};
            r_wr_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage write
    always_ff @(posedge i_clk) begin
        if (i_rst_n && i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    prefetch_fifo_chk #(.DEPTH(DEPTH)) u_chk (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (i_push),
        .i_flush (i_flush),
        .i_count (r_count)
    );

endmodule

// Credit scheme guarantees a free slot for every returning word.
module prefetch_fifo_chk #(
    parameter int  DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic          i_flush,
    input  logic [CW-1:0] i_count
);

    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(i_push && !i_flush && (i_count == CW'(DEPTH))));

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch stage: owns the fetch PC, issues credit-limited word reads and feeds decode from a prefetch queue.
module fetch_prefetch_unit
    import fetch_prefetch_unit_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                    clk1,
    input  logic                    rst_n,
    output logic                    mem_req,
    output logic [31:0]             mem_addr,
    input  logic                    mem_ready,
    input  logic [31:0]             mem_rdata,
    input  logic                    branch_valid,
    input  logic [31:0]             branch_target,
    input  logic                    dec_ready,
    output logic                    instr_valid,
    output logic [31:0]             instr,
    output logic [31:0]             instr_pc,
    output logic [$clog2(DEPTH):0]  q_count
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [CW-1:0] FULL_M1 = CW'(DEPTH - 1);

    fetch_state_e  r_state;
    fetch_state_e  w_state_n;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   w_fetch_pc_n;
    logic [31:0]   r_mem_addr;
    logic [31:0]   w_mem_addr_n;
    logic          r_mem_req;
    logic          w_push;
    logic          w_pop;
    logic          w_credit_after;
    logic [31:0]   w_target;
    logic [CW-1:0] w_count;
    fetch_entry_t  w_head;
    fetch_entry_t  w_wdata;

    assign w_target       = word_align(branch_target);
    assign instr_valid    = (w_count != {CW{1'b0}});
    assign w_pop          = instr_valid && dec_ready;
    // A same-edge pop frees the slot the returning word takes
    assign w_credit_after = w_pop || (w_count < FULL_M1);
    assign w_wdata        = '{pc: r_mem_addr, word: mem_rdata};

    // Next-state, next fetch PC and next request address
    always_comb begin
        w_state_n    = r_state;
        w_fetch_pc_n = r_fetch_pc;
        w_mem_addr_n = r_mem_addr;
        w_push       = 1'b0;
        case (r_state)
            FETCH_IDLE: begin
                if (branch_valid) begin
                    w_state_n    = FETCH_REQ;
                    w_fetch_pc_n = w_target;
                    w_mem_addr_n = w_target;
                end else if (w_count < FULL) begin
                    w_state_n    = FETCH_REQ;
                    w_mem_addr_n = r_fetch_pc;
                end else begin
                    w_state_n    = FETCH_IDLE;
                end
            end
            FETCH_REQ: begin
                if (branch_valid) begin
                    w_fetch_pc_n = w_target;
                    if (mem_ready) begin
                        w_state_n    = FETCH_REQ;
                        w_mem_addr_n = w_target;
                    end else begin
                        w_state_n    = FETCH_DRAIN;
                    end
                end else if (mem_ready) begin
                    w_push       = 1'b1;
                    w_fetch_pc_n = next_word(r_fetch_pc);
                    w_mem_addr_n = next_word(r_fetch_pc);
                    w_state_n    = w_credit_after ? FETCH_REQ : FETCH_IDLE;
                end else begin
                    w_state_n    = FETCH_REQ;
                end
            end
            FETCH_DRAIN: begin
                // Stale word is dropped; a branch landing on the same edge still redirects
                if (mem_ready) begin
                    w_state_n    = FETCH_REQ;
                    w_fetch_pc_n = branch_valid ? w_target : r_fetch_pc;
                    w_mem_addr_n = branch_valid ? w_target : r_fetch_pc;
                end else if (branch_valid) begin
                    w_fetch_pc_n = w_target;
                end else begin
                    w_state_n    = FETCH_DRAIN;
                end
            end
            default: begin
                w_state_n    = FETCH_IDLE;
                w_fetch_pc_n = RESET_PC;
                w_mem_addr_n = RESET_PC;
            end
        endcase
    end

    // FSM, fetch PC and registered memory request
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            r_state    <= FETCH_IDLE;
            r_fetch_pc <= RESET_PC;
            r_mem_addr <= RESET_PC;
            r_mem_req  <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_fetch_pc <= w_fetch_pc_n;
            r_mem_addr <= w_mem_addr_n;
            r_mem_req  <= (w_state_n != FETCH_IDLE);
        end
    end

    prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk   (clk1),
        .i_rst_n (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (branch_valid),
        .i_wdata (w_wdata),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign mem_req  = r_mem_req;
    assign mem_addr = r_mem_addr;
    assign q_count  = w_count;
    assign instr    = instr_valid ? w_head.word : 32'h0000_0000;
    assign instr_pc = instr_valid ? w_head.pc   : 32'h0000_0000;

endmodule
